// File: rtl/gray_counter_n_if.sv
// Control and status bundle for gray_counter_n: the counter controls and
// the registered binary, Gray, terminal-count and saturation outputs.
interface gray_counter_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc;
    logic             sat;

    modport master (
        output clr, load, load_bin, en, up,
        input  bin_q, gray_q, tc, sat
    );

    modport slave (
        input  clr, load, load_bin, en, up,
        output bin_q, gray_q, tc, sat
    );
endinterface

// File: rtl/gray_counter_n.sv
// Up/down binary counter with a registered Gray-code copy, sync clear/load,
// and either modulo wrap or saturation at the range limits.
module gray_counter_n #(
    parameter int unsigned      WIDTH     = 4,
    parameter bit               WRAP      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    gray_counter_n_if.slave bus
);
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_r;
    logic             tc_r;
    logic             tc_nxt;
    logic             sat_r;
    logic             sat_nxt;
    logic             at_lim;

    always_comb begin
        bin_nxt = bin_r;
        tc_nxt  = 1'b0;
        sat_nxt = sat_r;
        at_lim  = bus.up ? (bin_r == '1) : (bin_r == '0);
        if (bus.clr) begin
            bin_nxt = '0;
            sat_nxt = 1'b0;
        end else if (bus.load) begin
            bin_nxt = bus.load_bin;
            sat_nxt = 1'b0;
        end else if (bus.en) begin
            if (at_lim) begin
                tc_nxt = 1'b1;
                if (WRAP) begin
                    bin_nxt = bus.up ? '0 : '1;
                    sat_nxt = 1'b0;
                end else begin
                    sat_nxt = 1'b1;
                end
            end else begin
                // Landing on a limit does not flag sat; only the next push into it does.
                bin_nxt = bus.up ? bin_r + 1'b1 : bin_r - 1'b1;
                sat_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= RESET_VAL;
            gray_r <= RESET_GRAY;
            tc_r   <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            bin_r  <= bin_nxt;
            gray_r <= bin_nxt ^ (bin_nxt >> 1);
            tc_r   <= tc_nxt;
            sat_r  <= sat_nxt;
        end
    end

    assign bus.bin_q  = bin_r;
    assign bus.gray_q = gray_r;
    assign bus.tc     = tc_r;
    assign bus.sat    = sat_r;
endmodule

// File: tb/tb_gray_counter_n.sv
// Directed-vector and random-model bench for gray_counter_n in wrap (A),
// saturate (B) and 8-bit saturate (C) configurations.
module tb_gray_counter_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gray_counter_n_if #(.WIDTH(4)) ia ();
    gray_counter_n_if #(.WIDTH(4)) ib ();
    gray_counter_n_if #(.WIDTH(8)) ic ();

    gray_counter_n #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'd5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    gray_counter_n #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'd0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    gray_counter_n #(.WIDTH(8), .WRAP(1'b0), .RESET_VAL(8'd0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    typedef struct {
        bit       sel;      // 0 = dut_a (wrap), 1 = dut_b (saturate)
        bit       clr;
        bit       load;
        bit [3:0] ld;
        bit       en;
        bit       up;
        bit [3:0] bin;
        bit [3:0] gray;
        bit       tc;
        bit       sat;
        bit       onebit;   // Gray output must differ from previous in exactly one bit
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit sel, bit clr, bit load, bit [3:0] ld, bit en, bit up,
                                bit [3:0] bin, bit [3:0] gray, bit tc, bit sat, bit onebit);
        vec_t v;
        v.sel = sel; v.clr = clr; v.load = load; v.ld = ld; v.en = en; v.up = up;
        v.bin = bin; v.gray = gray; v.tc = tc; v.sat = sat; v.onebit = onebit;
        return v;
    endfunction

    function automatic bit [3:0] g4(input bit [3:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive4(input bit sel, input bit clr, input bit load, input bit [3:0] ld,
                          input bit en, input bit up);
        ia.clr = 1'b0; ia.load = 1'b0; ia.load_bin = '0; ia.en = 1'b0; ia.up = 1'b0;
        ib.clr = 1'b0; ib.load = 1'b0; ib.load_bin = '0; ib.en = 1'b0; ib.up = 1'b0;
        if (!sel) begin
            ia.clr = clr; ia.load = load; ia.load_bin = ld; ia.en = en; ia.up = up;
        end else begin
            ib.clr = clr; ib.load = load; ib.load_bin = ld; ib.en = en; ib.up = up;
        end
    endtask

    initial begin
        vec_t     v;
        bit [3:0] pre;
        bit [3:0] b;
        int       mb, mt, ms, r;
        bit       dir;
        logic [7:0] cbin;

        drive4(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        ic.clr = 1'b0; ic.load = 1'b0; ic.load_bin = '0; ic.en = 1'b0; ic.up = 1'b0;

        // Wrap-mode counting from 0 over the 15->0 boundary
        vq.push_back(mk(0, 1, 0, 4'd0, 0, 0, 4'd0, 4'b0000, 0, 0, 0));
        for (int i = 1; i <= 20; i++) begin
            b = 4'(i % 16);
            vq.push_back(mk(0, 0, 0, 4'd0, 1, 1, b, g4(b), (b == 4'd0), 0, 1));
        end
        // Wrap down from 0
        vq.push_back(mk(0, 0, 1, 4'd0, 0, 0, 4'd0,  4'b0000, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 4'd0, 1, 0, 4'd15, 4'b1000, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 4'd0, 1, 0, 4'd14, 4'b1001, 0, 0, 1));
        // Priority clr > load > en
        vq.push_back(mk(0, 1, 1, 4'd9, 1, 1, 4'd0, 4'b0000, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 4'd9, 1, 1, 4'd9, 4'b1101, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 4'd3, 0, 1, 4'd9, 4'b1101, 0, 0, 0));
        // Saturate at top, then leave the limit
        vq.push_back(mk(1, 0, 1, 4'd14, 0, 0, 4'd14, 4'b1001, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'd0,  1, 1, 4'd15, 4'b1000, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 4'd0,  1, 1, 4'd15, 4'b1000, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 4'd0,  1, 1, 4'd15, 4'b1000, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 4'd0,  1, 1, 4'd15, 4'b1000, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 4'd0,  1, 0, 4'd14, 4'b1001, 0, 0, 1));
        // Saturate at bottom, leave upward, then clr drops sat
        vq.push_back(mk(1, 0, 1, 4'd1, 0, 0, 4'd1, 4'b0001, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 4'd0, 1, 0, 4'd0, 4'b0000, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 4'd0, 1, 0, 4'd0, 4'b0000, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 4'd0, 1, 1, 4'd1, 4'b0001, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 4'd0, 1, 0, 4'd0, 4'b0000, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 4'd0, 1, 0, 4'd0, 4'b0000, 1, 1, 0));
        vq.push_back(mk(1, 1, 0, 4'd0, 1, 0, 4'd0, 4'b0000, 0, 0, 0));

        #12;
        chk("rst A bin", ia.bin_q, 5);
        chk("rst A gray", ia.gray_q, 7);
        chk("rst A tc", ia.tc, 0);
        chk("rst A sat", ia.sat, 0);
        chk("rst B bin", ib.bin_q, 0);
        chk("rst B gray", ib.gray_q, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            pre = v.sel ? ib.gray_q : ia.gray_q;
            drive4(v.sel, v.clr, v.load, v.ld, v.en, v.up);
            @(posedge clk); #1;
            if (!v.sel) begin
                chk($sformatf("v%0d A bin", i), ia.bin_q, v.bin);
                chk($sformatf("v%0d A gray", i), ia.gray_q, v.gray);
                chk($sformatf("v%0d A tc", i), ia.tc, v.tc);
                chk($sformatf("v%0d A sat", i), ia.sat, v.sat);
                if (v.onebit) chk($sformatf("v%0d A gray step", i), $countones(pre ^ ia.gray_q), 1);
            end else begin
                chk($sformatf("v%0d B bin", i), ib.bin_q, v.bin);
                chk($sformatf("v%0d B gray", i), ib.gray_q, v.gray);
                chk($sformatf("v%0d B tc", i), ib.tc, v.tc);
                chk($sformatf("v%0d B sat", i), ib.sat, v.sat);
                if (v.onebit) chk($sformatf("v%0d B gray step", i), $countones(pre ^ ib.gray_q), 1);
            end
        end

        // Asynchronous reset mid-cycle while counting at 7
        drive4(0, 0, 1, 4'd4, 0, 0);
        @(posedge clk); #1;
        drive4(0, 0, 0, 4'd0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-rst A bin", ia.bin_q, 7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async A bin", ia.bin_q, 5);
        chk("async A gray", ia.gray_q, 7);
        chk("async A tc", ia.tc, 0);
        chk("async A sat", ia.sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst A bin", ia.bin_q, 6);
        chk("post-rst A gray", ia.gray_q, 5);
        chk("post-rst A tc", ia.tc, 0);
        drive4(0, 0, 0, 4'd0, 0, 0);

        // 8-bit saturating counter against a reference model
        mb = 0; mt = 0; ms = 0; dir = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (c % 400 == 0) dir = ~dir;
            r = $urandom_range(99);
            ic.clr  = (r < 2);
            ic.load = (r >= 2 && r < 6);
            case ($urandom_range(4))
                0: ic.load_bin = 8'd0;
                1: ic.load_bin = 8'd255;
                2: ic.load_bin = 8'd254;
                3: ic.load_bin = 8'd1;
                default: ic.load_bin = 8'($urandom_range(255));
            endcase
            ic.en = ($urandom_range(99) < 80);
            ic.up = ($urandom_range(99) < 85) ? dir : ~dir;

            if (ic.clr) begin
                mb = 0; mt = 0; ms = 0;
            end else if (ic.load) begin
                mb = int'(ic.load_bin); mt = 0; ms = 0;
            end else if (ic.en) begin
                if (ic.up && mb == 255)      begin mt = 1; ms = 1; end
                else if (!ic.up && mb == 0)  begin mt = 1; ms = 1; end
                else begin mb = ic.up ? mb + 1 : mb - 1; mt = 0; ms = 0; end
            end else begin
                mt = 0;
            end

            @(posedge clk); #1;
            cbin = ic.bin_q;
            chk($sformatf("c%0d C bin", c), ic.bin_q, mb);
            chk($sformatf("c%0d C tc", c), ic.tc, mt);
            chk($sformatf("c%0d C sat", c), ic.sat, ms);
            chk($sformatf("c%0d C gray", c), ic.gray_q, mb ^ (mb >> 1));
            chk($sformatf("c%0d C gray/bin", c), ic.gray_q, cbin ^ (cbin >> 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
